spi_slave_param: RTL and testbench

Parametrised second-generation SPI slave for the ping-pong RAM front end.
- Oversamples sck/ssel/mosi in the system clk domain.
- Supports all four CPOL/CPHA modes, configurable word width and bit order.
- Handles back-to-back multi-word frames within one ssel assertion.
- Hands received words to, and requests transmit words from, the ping-pong RAM controller via single-cycle strobes.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_slave_param.sv | 214 +++++++++++++++++++++
 tb/tb_spi_slave_param.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI slave: mode encodings,
// FSM state enum and the bit-counter width function.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } spi_state_e;

  function automatic int spi_cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

  // Mode number is {CPOL, CPHA}
  function automatic spi_mode_e spi_mode(input bit cpol, input bit cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by a history
// flop so rising/falling edges can be derived from the last two samples.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Reset to the pin's idle level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_hist;
  assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/spi_slave_param.sv
// Oversampling SPI slave (all CPOL/CPHA modes) for the ping-pong RAM front end.
// Optional feature: define SPI_SLAVE_WORDCNT_EN to add the 16-bit word_cnt output.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ssel,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              tx_req,
  input  logic [DATA_W-1:0] tx_data,
  output logic              frame_abort
`ifdef SPI_SLAVE_WORDCNT_EN
  ,
  output logic [15:0]       word_cnt
`endif
);

  localparam int                CNT_W        = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT     = CNT_W'(DATA_W - 1);
  localparam spi_mode_e         MODE         = spi_mode(CPOL != 0, CPHA != 0);
  localparam bit                LEAD_IS_FALL = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
  localparam bit                SAMPLE_TRAIL = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
  localparam bit                MSB_FST      = (MSB_FIRST != 0);

  spi_state_e        r_state;
  spi_state_e        w_next_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_rx_valid;
  logic              r_reload;
  logic              r_miso;

  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_ssel_lvl, w_ssel_rise, w_ssel_fall;
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
  logic w_lead, w_trail, w_sample_edge, w_shift_edge;
  logic w_in_frame, w_word_done;
  logic w_tx_first, w_load_first;
  logic [DATA_W-1:0] w_rx_next, w_tx_shifted;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_sync_sck (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sck),
    .o_level (w_sck_lvl),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ssel),
    .o_level (w_ssel_lvl),
    .o_rise  (w_ssel_rise),
    .o_fall  (w_ssel_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (mosi),
    .o_level (w_mosi_lvl),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  assign w_unused = ^{w_sck_lvl, w_ssel_rise, w_mosi_rise, w_mosi_fall};

  assign w_lead        = LEAD_IS_FALL ? w_sck_fall : w_sck_rise;
  assign w_trail       = LEAD_IS_FALL ? w_sck_rise : w_sck_fall;
  assign w_sample_edge = SAMPLE_TRAIL ? w_trail : w_lead;
  assign w_shift_edge  = SAMPLE_TRAIL ? w_lead : w_trail;

  // Edges only count while the synchronised select is still low
  assign w_in_frame  = (r_state == ACTIVE) && !w_ssel_lvl;
  assign w_word_done = w_in_frame && w_sample_edge && (r_bit_cnt == LAST_BIT);

  assign w_rx_next    = MSB_FST ? {r_rx_shift[DATA_W-2:0], w_mosi_lvl}
                                : {w_mosi_lvl, r_rx_shift[DATA_W-1:1]};
  assign w_tx_shifted = MSB_FST ? {r_tx_shift[DATA_W-2:0], 1'b0}
                                : {1'b0, r_tx_shift[DATA_W-1:1]};
  assign w_tx_first   = MSB_FST ? r_tx_shift[DATA_W-1] : r_tx_shift[0];
  assign w_load_first = MSB_FST ? tx_data[DATA_W-1] : tx_data[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_ssel_fall) w_next_state = LOAD;
      LOAD:    w_next_state = ACTIVE;
      ACTIVE:  if (w_ssel_lvl) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    miso_oe     = 1'b0;
    tx_req      = 1'b0;
    frame_abort = 1'b0;
    case (r_state)
      IDLE: tx_req = w_ssel_fall;
      LOAD: miso_oe = 1'b1;
      ACTIVE: begin
        miso_oe     = 1'b1;
        tx_req      = w_word_done;
        frame_abort = w_ssel_lvl && (r_bit_cnt != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_tx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_reload   <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_reload   <= 1'b0;
      case (r_state)
        LOAD: begin
          r_tx_shift <= tx_data;
          r_bit_cnt  <= '0;
          r_miso     <= SAMPLE_TRAIL ? 1'b0 : w_load_first;
        end
        ACTIVE: begin
          if (w_ssel_lvl) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_miso     <= 1'b0;
          end else begin
            if (w_sample_edge) begin
              r_rx_shift <= w_rx_next;
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt  <= '0;
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                r_reload   <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
            // CPHA=0 skips the shift edge right after a word's last sample;
            // the reload has already put the next first bit on miso.
            if (r_reload) begin
              r_tx_shift <= tx_data;
              if (!SAMPLE_TRAIL) r_miso <= w_load_first;
            end else if (w_shift_edge) begin
              if (SAMPLE_TRAIL) begin
                r_miso     <= w_tx_first;
                r_tx_shift <= w_tx_shifted;
              end else if (r_bit_cnt != '0) begin
                r_miso     <= MSB_FST ? w_tx_shifted[DATA_W-1] : w_tx_shifted[0];
                r_tx_shift <= w_tx_shifted;
              end
            end
          end
        end
        default: begin
          r_bit_cnt <= '0;
          r_miso    <= 1'b0;
        end
      endcase
    end
  end

  assign miso     = r_miso;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

`ifdef SPI_SLAVE_WORDCNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_word_cnt <= '0;
    end else if (w_word_done && (r_word_cnt != 16'hFFFF)) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: a mode-0 8-bit MSB-first slave and a mode-3
// 16-bit LSB-first slave, each driven by a behavioural SPI master.
module tb_spi_slave_param;

  localparam int HP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic       sck0, ssel0, mosi0, miso0, misoOe0, rxValid0, txReq0, frameAbort0;
  logic [7:0] rxData0, txData0;

  logic        sck1, ssel1, mosi1, miso1, misoOe1, rxValid1, txReq1, frameAbort1;
  logic [15:0] rxData1, txData1;

`ifdef SPI_SLAVE_WORDCNT_EN
  logic [15:0] wordCnt0, wordCnt1;
`endif

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rstN), .sck(sck0), .ssel(ssel0), .mosi(mosi0),
    .miso(miso0), .miso_oe(misoOe0), .rx_valid(rxValid0), .rx_data(rxData0),
    .tx_req(txReq0), .tx_data(txData0), .frame_abort(frameAbort0)
`ifdef SPI_SLAVE_WORDCNT_EN
    , .word_cnt(wordCnt0)
`endif
  );

  spi_slave_param #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rstN), .sck(sck1), .ssel(ssel1), .mosi(mosi1),
    .miso(miso1), .miso_oe(misoOe1), .rx_valid(rxValid1), .rx_data(rxData1),
    .tx_req(txReq1), .tx_data(txData1), .frame_abort(frameAbort1)
`ifdef SPI_SLAVE_WORDCNT_EN
    , .word_cnt(wordCnt1)
`endif
  );

  int testsRun = 0;
  int testsFailed = 0;
  int rxValidCnt[2];
  int abortCnt[2];
  int txReqCnt[2];
  logic [31:0] lastRx[2];
  logic [31:0] expRx0[$];
  logic [31:0] expRx1[$];
  logic [31:0] txQ0[$];
  logic [31:0] txQ1[$];

  // Per-slave configuration as the master sees it
  function automatic int dutWidth(input int d);
    return (d == 0) ? 8 : 16;
  endfunction
  function automatic bit dutCpol(input int d);
    return (d != 0);
  endfunction
  function automatic bit dutCpha(input int d);
    return (d != 0);
  endfunction
  function automatic bit dutMsb(input int d);
    return (d == 0);
  endfunction

  function automatic logic [31:0] rdRxData(input int d);
    return (d == 0) ? {24'd0, rxData0} : {16'd0, rxData1};
  endfunction
  function automatic logic rdRxValid(input int d);
    return (d == 0) ? rxValid0 : rxValid1;
  endfunction
  function automatic logic rdAbort(input int d);
    return (d == 0) ? frameAbort0 : frameAbort1;
  endfunction
  function automatic logic rdTxReq(input int d);
    return (d == 0) ? txReq0 : txReq1;
  endfunction
  function automatic logic rdMiso(input int d);
    return (d == 0) ? miso0 : miso1;
  endfunction
  function automatic logic rdMisoOe(input int d);
    return (d == 0) ? misoOe0 : misoOe1;
  endfunction

  function automatic void pushExp(input int d, input logic [31:0] v);
    if (d == 0) expRx0.push_back(v);
    else expRx1.push_back(v);
  endfunction

  function automatic bit popExp(input int d, output logic [31:0] v);
    v = '0;
    if (d == 0) begin
      if (expRx0.size() == 0) return 1'b0;
      v = expRx0.pop_front();
    end else begin
      if (expRx1.size() == 0) return 1'b0;
      v = expRx1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] popTx(input int d);
    if (d == 0) return (txQ0.size() != 0) ? txQ0.pop_front() : 32'd0;
    return (txQ1.size() != 0) ? txQ1.pop_front() : 32'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setSck(input int d, input logic v);
    if (d == 0) sck0 = v; else sck1 = v;
  endtask
  task automatic setSsel(input int d, input logic v);
    if (d == 0) ssel0 = v; else ssel1 = v;
  endtask
  task automatic setMosi(input int d, input logic v);
    if (d == 0) mosi0 = v; else mosi1 = v;
  endtask

  // Scoreboard, tx_data responder and per-cycle invariants
  initial begin
    logic [31:0] e;
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      rxValidCnt[d] = 0;
      abortCnt[d]   = 0;
      txReqCnt[d]   = 0;
      lastRx[d]     = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rstN) begin
          lastRx[d] = '0;
        end else begin
          checkOutput($sformatf("dut%0d rx_valid with frame_abort", d),
                      {31'd0, rdRxValid(d) & rdAbort(d)}, 32'd0);
          if (rdRxValid(d)) begin
            rxValidCnt[d]++;
            if (popExp(d, e)) begin
              checkOutput($sformatf("dut%0d rx_data on rx_valid", d), rdRxData(d), e);
              lastRx[d] = e;
            end else begin
              failNow($sformatf("dut%0d rx_valid with no word sent", d));
            end
          end else begin
            checkOutput($sformatf("dut%0d rx_data hold", d), rdRxData(d), lastRx[d]);
          end
          if (!rdMisoOe(d))
            checkOutput($sformatf("dut%0d miso while disabled", d), {31'd0, rdMiso(d)}, 32'd0);
          if (rdAbort(d)) abortCnt[d]++;
          if (rdTxReq(d)) begin
            txReqCnt[d]++;
            v = popTx(d);
            if (d == 0) txData0 = v[7:0];
            else txData1 = v[15:0];
          end
        end
      end
    end
  end

  // Behavioural master: one word (or a partial word) in the slave's mode
  task automatic spiWord(input int d, input logic [31:0] mosiWord, input int nbits,
                         output logic [31:0] misoWord);
    int w;
    int idx;
    bit cpol;
    bit cpha;
    w = dutWidth(d);
    cpol = dutCpol(d);
    cpha = dutCpha(d);
    misoWord = '0;
    if (nbits == w) pushExp(d, mosiWord);
    for (int i = 0; i < nbits; i++) begin
      idx = dutMsb(d) ? (w - 1 - i) : i;
      if (!cpha) begin
        setMosi(d, mosiWord[idx]);
        waitClk(HP);
        misoWord[idx] = rdMiso(d);
        setSck(d, !cpol);
        waitClk(HP);
        setSck(d, cpol);
      end else begin
        setSck(d, !cpol);
        setMosi(d, mosiWord[idx]);
        waitClk(HP);
        misoWord[idx] = rdMiso(d);
        setSck(d, cpol);
        waitClk(HP);
      end
    end
  endtask

  task automatic frameStart(input int d);
    setSsel(d, 1'b0);
    waitClk(HP);
  endtask

  task automatic frameEnd(input int d);
    waitClk(HP);
    setSsel(d, 1'b1);
    setMosi(d, 1'b0);
    waitClk(2 * HP);
  endtask

  task automatic applyStimulus(input int d, input int nWords,
                               input logic [31:0] mosiW [4], input logic [31:0] txW [4]);
    logic [31:0] rd;
    if (d == 0) txQ0.delete(); else txQ1.delete();
    for (int k = 0; k < nWords; k++) begin
      if (d == 0) txQ0.push_back(txW[k]); else txQ1.push_back(txW[k]);
    end
    frameStart(d);
    for (int k = 0; k < nWords; k++) begin
      spiWord(d, mosiW[k], dutWidth(d), rd);
      checkOutput($sformatf("dut%0d miso word %0d", d, k), rd, txW[k]);
    end
    frameEnd(d);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, r0, a0;
    logic [31:0] junk;
    bit seen;

    rstN = 1'b0;
    sck0 = 1'b0; ssel0 = 1'b1; mosi0 = 1'b0; txData0 = '0;
    sck1 = 1'b1; ssel1 = 1'b1; mosi1 = 1'b0; txData1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset miso", {31'd0, miso0}, 32'd0);
    checkOutput("reset miso_oe", {31'd0, misoOe0}, 32'd0);
    checkOutput("reset rx_valid", {31'd0, rxValid0}, 32'd0);
    checkOutput("reset rx_data", {24'd0, rxData0}, 32'd0);
    checkOutput("reset tx_req", {31'd0, txReq0}, 32'd0);
    checkOutput("reset frame_abort", {31'd0, frameAbort0}, 32'd0);
    checkOutput("reset rx_data dut1", {16'd0, rxData1}, 32'd0);
    rstN = 1'b1;
    waitClk(4);

    // Mode 0: two back-to-back words in one frame
    t0 = txReqCnt[0];
    r0 = rxValidCnt[0];
    applyStimulus(0, 2, '{32'h9B, 32'h00, 32'h0, 32'h0}, '{32'h9B, 32'h00, 32'h0, 32'h0});
    checkOutput("mode0 tx_req pulses", txReqCnt[0] - t0, 3);
    checkOutput("mode0 rx_valid pulses", rxValidCnt[0] - r0, 2);
    checkOutput("mode0 final rx_data", {24'd0, rxData0}, 32'h00);
    checkOutput("mode0 miso_oe after end", {31'd0, misoOe0}, 32'd0);

    // Mode 3, 16-bit LSB-first
    t0 = txReqCnt[1];
    applyStimulus(1, 1, '{32'hA55A, 32'h0, 32'h0, 32'h0}, '{32'h1234, 32'h0, 32'h0, 32'h0});
    checkOutput("mode3 rx_data", {16'd0, rxData1}, 32'hA55A);
    checkOutput("mode3 tx_req pulses", txReqCnt[1] - t0, 2);

    // Abort after 5 bits of 8'hF0
    r0 = rxValidCnt[0];
    a0 = abortCnt[0];
    txQ0.delete();
    txQ0.push_back(32'hA5);
    frameStart(0);
    spiWord(0, 32'hF0, 5, junk);
    checkOutput("abort partial miso bits", junk & 32'hF8, 32'hA0);
    checkOutput("abort miso_oe mid-frame", {31'd0, misoOe0}, 32'd1);
    waitClk(HP);
    setSsel(0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frameAbort0) seen = 1'b1;
    end
    if (!seen) begin
      failNow("abort pulse timeout");
    end else begin
      @(negedge clk);
      checkOutput("abort miso_oe next cycle", {31'd0, misoOe0}, 32'd0);
      checkOutput("abort miso next cycle", {31'd0, miso0}, 32'd0);
    end
    setMosi(0, 1'b0);
    waitClk(2 * HP);
    checkOutput("abort pulses", abortCnt[0] - a0, 1);
    checkOutput("abort rx_valid pulses", rxValidCnt[0] - r0, 0);
    checkOutput("abort rx_data kept", {24'd0, rxData0}, 32'h00);

    // Reset after 3 bits of a word, then a clean word
    frameStart(0);
    spiWord(0, 32'hC3, 3, junk);
    rstN = 1'b0;
    setSsel(0, 1'b1);
    setSck(0, 1'b0);
    setMosi(0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("rst miso", {31'd0, miso0}, 32'd0);
    checkOutput("rst miso_oe", {31'd0, misoOe0}, 32'd0);
    checkOutput("rst rx_valid", {31'd0, rxValid0}, 32'd0);
    checkOutput("rst rx_data", {24'd0, rxData0}, 32'd0);
    checkOutput("rst tx_req", {31'd0, txReq0}, 32'd0);
    checkOutput("rst frame_abort", {31'd0, frameAbort0}, 32'd0);
    waitClk(HP);
    applyStimulus(0, 1, '{32'h3C, 32'h0, 32'h0, 32'h0}, '{32'h5A, 32'h0, 32'h0, 32'h0});
    checkOutput("post-reset rx_data", {24'd0, rxData0}, 32'h3C);

`ifdef SPI_SLAVE_WORDCNT_EN
    applyStimulus(0, 4, '{32'h11, 32'h22, 32'h33, 32'h44}, '{32'h81, 32'h42, 32'h24, 32'h18});
    checkOutput("word_cnt after frame", {16'd0, wordCnt0}, 32'd4);
    frameStart(0);
    checkOutput("word_cnt at next frame", {16'd0, wordCnt0}, 32'd0);
    frameEnd(0);
`endif

    waitClk(4);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
